// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply / multiply-accumulate / divide unit for the EX stage.
// One result bit per cycle on magnitudes; signs, accumulation and special cases
// are resolved in a single FIX cycle before the result is committed.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// CALC  | WIDTH shift-add or shift-subtract iterations
// FIX   | sign correction, accumulate, special cases, commit hi_out/lo_out
// DONE  | one-cycle done pulse
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             cancel,
    output logic             stall_req,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]         state;
    logic [1:0]         kind_q;     // op[2:1]: 00 mult, 01 div, 10 madd, 11 msub
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   hi_acc;
    logic [WIDTH-1:0]   lo_acc;
    logic               neg_q;
    logic               neg_r;
    logic [CW-1:0]      cnt;
    // Multiply: {partial sum, remaining multiplier bits}.
    // Divide:   {remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] work;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] work_nxt;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [2*WIDTH-1:0] result;

    assign is_signed = ~op[0];
    assign abs_a     = (is_signed && opa[WIDTH-1]) ? ({WIDTH{1'b0}} - opa) : opa;
    assign abs_b     = (is_signed && opb[WIDTH-1]) ? ({WIDTH{1'b0}} - opb) : opb;

    assign ready     = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign stall_req = (state == S_IDLE && start && !cancel) || state == S_CALC || state == S_FIX;

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        trial    = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]} - {1'b0, b_q};
        work_nxt = {mul_sum, work[WIDTH-1:1]};
        if (kind_q == 2'b01) begin
            if (trial[WIDTH])
                work_nxt = {work[2*WIDTH-2:0], 1'b0};
            else
                work_nxt = {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix, accumulate and divide-by-zero override, evaluated during FIX
    always_comb begin
        prod_s = neg_q ? ({(2*WIDTH){1'b0}} - work) : work;
        quot_s = neg_q ? ({WIDTH{1'b0}} - work[WIDTH-1:0]) : work[WIDTH-1:0];
        rem_s  = neg_r ? ({WIDTH{1'b0}} - work[2*WIDTH-1:WIDTH]) : work[2*WIDTH-1:WIDTH];
        case (kind_q)
            2'b01: begin
                if (b_q == {WIDTH{1'b0}})
                    result = {raw_a, {WIDTH{1'b1}}};
                else
                    result = {rem_s, quot_s};
            end
            2'b10:   result = {hi_acc, lo_acc} + prod_s;
            2'b11:   result = {hi_acc, lo_acc} - prod_s;
            default: result = prod_s;
        endcase
    end

    // FSM, operand capture, iteration and result commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            kind_q <= 2'b00;
            a_q    <= '0;
            b_q    <= '0;
            raw_a  <= '0;
            hi_acc <= '0;
            lo_acc <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            work   <= '0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        kind_q <= op[2:1];
                        a_q    <= abs_a;
                        b_q    <= abs_b;
                        raw_a  <= opa;
                        hi_acc <= hi_in;
                        lo_acc <= lo_in;
                        neg_q  <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        neg_r  <= is_signed & opa[WIDTH-1];
                        cnt    <= '0;
                        // divide shifts the dividend out; multiply shifts the multiplier out
                        work   <= (op[2:1] == 2'b01) ? {{WIDTH{1'b0}}, abs_a}
                                                     : {{WIDTH{1'b0}}, abs_b};
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        work <= work_nxt;
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1))
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        hi_out <= result[2*WIDTH-1:WIDTH];
                        lo_out <= result[WIDTH-1:0];
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
